// File: rtl/pq_rr_burst_arbiter.sv
// Round-robin burst arbiter: rotating-priority lowest-set-bit selection, registered
// burst ownership with a ready handshake, last-beat completion, abort and max-length preemption.
module pq_rr_burst_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         req_vec,
    input  logic [WIDTH-1:0]         last_vec,
    input  logic                     ready,
    output logic                     grant_valid,
    output logic [WIDTH-1:0]         grant_one_hot,
    output logic [$clog2(WIDTH)-1:0] grant_index,
    output logic                     beat_fire,
    output logic                     burst_end,
    output logic                     burst_abort,
    output logic                     preempt
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   owner_oh_q, owner_oh_d;
    logic [IDX_W-1:0]   owner_idx_q, owner_idx_d;
    logic [WIDTH-1:0]   prio_mask_q, prio_mask_d;
    logic [CNT_W-1:0]   beat_count_q, beat_count_d;
    logic [WIDTH-1:0]   win_oh;

    logic granted;
    logic owner_req;
    logic owner_last;
    logic cnt_at_max;
    logic fire_w;
    logic abort_w;
    logic preempt_w;
    logic end_w;

    // Isolate the lowest set bit with the two's-complement trick.
    function automatic logic [WIDTH-1:0] lsb_oh(input logic [WIDTH-1:0] v);
        return v & (~v + WIDTH'(1));
    endfunction

    // Prefer requesters above the last owner; fall back to plain lowest-set-bit.
    function automatic logic [WIDTH-1:0] sel_oh(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] mask);
        logic [WIDTH-1:0] m;
        m = v & mask;
        return (|m) ? lsb_oh(m) : lsb_oh(v);
    endfunction

    // Bits strictly above the one-hot position; all-zero for the top requester.
    function automatic logic [WIDTH-1:0] cold_mask(input logic [WIDTH-1:0] oh);
        return ~(oh | (oh - WIDTH'(1)));
    endfunction

    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [WIDTH-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Per-cycle burst events for the current owner; abort wins since no beat can fire.
    assign granted    = (state_q == GRANTED);
    assign owner_req  = |(req_vec & owner_oh_q);
    assign owner_last = |(last_vec & owner_oh_q);
    assign cnt_at_max = (beat_count_q == CNT_W'(MAX_BEATS - 1));
    assign fire_w     = granted & owner_req & ready;
    assign abort_w    = granted & ~owner_req;
    assign preempt_w  = fire_w & ~owner_last & cnt_at_max;
    assign end_w      = fire_w & (owner_last | cnt_at_max);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            owner_oh_q   <= '0;
            owner_idx_q  <= '0;
            prio_mask_q  <= '1;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_oh_q   <= owner_oh_d;
            owner_idx_q  <= owner_idx_d;
            prio_mask_q  <= prio_mask_d;
            beat_count_q <= beat_count_d;
        end
    end

    // Next-state: arbitration from IDLE, handoff at burst end, beat counting otherwise.
    always_comb begin
        state_d      = state_q;
        owner_oh_d   = owner_oh_q;
        owner_idx_d  = owner_idx_q;
        prio_mask_d  = prio_mask_q;
        beat_count_d = beat_count_q;
        win_oh       = '0;

        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    win_oh       = sel_oh(req_vec, prio_mask_q);
                    state_d      = GRANTED;
                    owner_oh_d   = win_oh;
                    owner_idx_d  = oh_to_idx(win_oh);
                    beat_count_d = '0;
                end
            end
            GRANTED: begin
                if (end_w || abort_w) begin
                    // Outgoing owner is excluded so a lone requester takes one idle bubble.
                    prio_mask_d  = cold_mask(owner_oh_q);
                    win_oh       = sel_oh(req_vec & ~owner_oh_q, prio_mask_d);
                    beat_count_d = '0;
                    if (|win_oh) begin
                        state_d     = GRANTED;
                        owner_oh_d  = win_oh;
                        owner_idx_d = oh_to_idx(win_oh);
                    end else begin
                        state_d     = IDLE;
                        owner_oh_d  = '0;
                        owner_idx_d = '0;
                    end
                end else if (fire_w) begin
                    beat_count_d = beat_count_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Outputs: grant straight from registers, event pulses suppressed while in reset.
    always_comb begin
        grant_valid   = granted;
        grant_one_hot = owner_oh_q;
        grant_index   = owner_idx_q;
        beat_fire     = fire_w & ~RST;
        burst_end     = end_w & ~RST;
        burst_abort   = abort_w & ~RST;
        preempt       = preempt_w & ~RST;
    end

endmodule

// File: tb/tb_pq_rr_burst_arbiter.sv
// Directed plus randomized bench for pq_rr_burst_arbiter, checked cycle by cycle
// against a behavioural arbitration model held as an owner number, a mask array and a beat counter.
module tb_pq_rr_burst_arbiter;

    localparam int W  = 4;
    localparam int MB = 4;

    logic         CLK;
    logic         RST;
    logic [W-1:0] req_vec;
    logic [W-1:0] last_vec;
    logic         ready;
    logic         grant_valid;
    logic [W-1:0] grant_one_hot;
    logic [1:0]   grant_index;
    logic         beat_fire;
    logic         burst_end;
    logic         burst_abort;
    logic         preempt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int m_owner;          // -1 when idle
    bit m_mask [W];
    int m_cnt;

    pq_rr_burst_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_vec       (req_vec),
        .last_vec      (last_vec),
        .ready         (ready),
        .grant_valid   (grant_valid),
        .grant_one_hot (grant_one_hot),
        .grant_index   (grant_index),
        .beat_fire     (beat_fire),
        .burst_end     (burst_end),
        .burst_abort   (burst_abort),
        .preempt       (preempt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Masked-first, then unmasked, lowest-index winner; -1 when nobody requests.
    function automatic int pick(input logic [W-1:0] v, input bit mask [W]);
        for (int i = 0; i < W; i++) if (v[i] && mask[i]) return i;
        for (int i = 0; i < W; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        for (int i = 0; i < W; i++) m_mask[i] = 1'b1;
    endtask

    // One clock cycle: drive, check model against DUT mid-cycle, then advance the model across the edge.
    task automatic step(input logic [W-1:0] rq, input logic [W-1:0] lst,
                        input logic rdy, input logic rst);
        bit g, oreq, e_fire, e_abort, e_pre, e_end;
        logic [W-1:0] v;
        int k;

        RST      = rst;
        req_vec  = rq;
        last_vec = lst;
        ready    = rdy;
        #3;

        g       = (m_owner >= 0);
        oreq    = g && rq[m_owner];
        e_abort = !rst && g && !oreq;
        e_fire  = !rst && g && oreq && rdy;
        e_pre   = e_fire && !lst[m_owner] && (m_cnt == MB - 1);
        e_end   = e_fire && (lst[m_owner] || (m_cnt == MB - 1));

        chk("grant_valid", 32'(grant_valid), 32'(g));
        chk("grant_one_hot", 32'(grant_one_hot), g ? (32'd1 << m_owner) : 32'd0);
        chk("grant_index", 32'(grant_index), g ? 32'(m_owner) : 32'd0);
        chk("beat_fire", 32'(beat_fire), 32'(e_fire));
        chk("burst_end", 32'(burst_end), 32'(e_end));
        chk("burst_abort", 32'(burst_abort), 32'(e_abort));
        chk("preempt", 32'(preempt), 32'(e_pre));

        @(posedge CLK);
        if (rst) begin
            model_reset();
        end else if (!g) begin
            m_owner = pick(rq, m_mask);
            m_cnt   = 0;
        end else if (e_end || e_abort) begin
            k = m_owner;
            for (int i = 0; i < W; i++) m_mask[i] = (i > k);
            v = rq;
            v[k] = 1'b0;
            m_owner = pick(v, m_mask);
            m_cnt   = 0;
        end else if (e_fire) begin
            m_cnt++;
        end
        #1;
    endtask

    initial begin
        RST      = 1'b1;
        req_vec  = '0;
        last_vec = '0;
        ready    = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;

        // Reset held with everyone requesting, then release
        step(4'b1111, 4'b0000, 1'b1, 1'b1);
        step(4'b1111, 4'b0000, 1'b1, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("post_reset_grant", 32'(grant_one_hot), 32'h1);

        // Single three-beat burst from requester 2
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b0100, 4'b0000, 1'b1, 1'b0);
        step(4'b0100, 4'b0000, 1'b1, 1'b0);
        step(4'b0100, 4'b0000, 1'b1, 1'b0);
        step(4'b0100, 4'b0100, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);

        // Back-to-back single-beat bursts with wrap past index 3
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1011, 4'b1111, 1'b1, 1'b0);

        // Ready stall on owner 1
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0010, 4'b0000, 1'b0, 1'b0);
        step(4'b0010, 4'b0010, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);

        // Preemption after MAX_BEATS beats
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(4'b0011, 4'b0000, 1'b1, 1'b0);

        // Abort by owner 2, handoff to 3 through the rotated mask
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b0100, 4'b0000, 1'b1, 1'b0);
        step(4'b0100, 4'b0000, 1'b1, 1'b0);
        step(4'b1001, 4'b0000, 1'b1, 1'b0);
        step(4'b1001, 4'b0000, 1'b1, 1'b0);
        chk("abort_handoff", 32'(grant_one_hot), 32'h8);

        // Reset mid-burst restores the all-ones mask
        step(4'b1010, 4'b0000, 1'b1, 1'b0);
        step(4'b1010, 4'b0000, 1'b1, 1'b1);
        step(4'b1010, 4'b0000, 1'b1, 1'b0);
        step(4'b1010, 4'b0000, 1'b1, 1'b0);
        chk("reset_mask_restore", 32'(grant_one_hot), 32'h2);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(W'($urandom), W'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pq_rr_burst_arbiter.md
# pq_rr_burst_arbiter

Round-robin burst arbiter that shares one downstream resource among WIDTH requesters. It extends pq_lsb lowest-set-bit selection with a rotating priority mask, a registered grant that is held for a multi-beat burst, a downstream ready handshake and a max-burst-length preemption counter. It sits between requesting pipeline queues and a single shared port, for example a shared writeback or issue bus.

## Interface
- WIDTH, default 8: number of requesters; must be ≥ 2.
- MAX_BEATS, default 4: beats after which a burst is force-ended; must be ≥ 1.

- CLK  input  1: clock; all state updates on posedge.
- RST  input  1: synchronous, active-high reset.
- req_vec  input  WIDTH: per-requester request. For the owner, high means "beat available".
- last_vec  input  WIDTH: per-requester last-beat flag; only the owner's bit is sampled.
- ready  input  1: downstream accepts a beat this cycle.
- grant_valid  output  1: a burst owner exists (registered).
- grant_one_hot  output  WIDTH: owner one-hot; 0 when grant_valid = 0 (registered).
- grant_index  output  clog2(WIDTH): owner index; 0 when grant_valid = 0 (registered).
- beat_fire  output  1: combinational; equals grant_valid & req_vec[owner] & ready.
- burst_end  output  1: combinational pulse on the final beat of a burst, from last or preemption.
- burst_abort  output  1: combinational pulse when the owner drops its req while granted.
- preempt  output  1: combinational pulse when a burst ends because beat_count hit MAX_BEATS.

## Operation
- State: IDLE or GRANTED. Registers: owner one-hot/index, prio_mask[WIDTH], beat_count[clog2(MAX_BEATS+1)].
- Selection function sel(v):
  - m = v & prio_mask.
  - If m ≠ 0, winner = lowest set bit of m; otherwise winner = lowest set bit of v.
  - If v = 0, there is no winner.
- IDLE:
  - If req_vec ≠ 0, go to GRANTED with owner = sel(req_vec) and beat_count = 0.
  - Otherwise stay in IDLE.
- GRANTED, owner k:
  - Beat: beat_fire = 1, which increments beat_count.
  - Completion (beat_fire & last_vec[k]): burst_end = 1.
  - Preemption (beat_fire & !last_vec[k] & beat_count == MAX_BEATS-1): burst_end = 1 and preempt = 1.
  - Abort (!req_vec[k]): burst_abort = 1; no beat fires. Abort takes precedence over any other event that cycle.
  - Stall (ready = 0 with req_vec[k] = 1): hold owner and beat_count.
- On any burst end, whether completion, preemption or abort:
  - prio_mask ← bits k+1..WIDTH-1 set, bits 0..k clear. The cold mask of k; all-zero when k = WIDTH-1, so priority wraps.
  - Re-arbitrate with v = req_vec & ~onehot(k) against the new prio_mask.
  - If a winner exists, go to GRANTED with the new owner and beat_count = 0 (no bubble).
  - Otherwise go to IDLE.
- The outgoing owner is always excluded from that cycle's re-arbitration. A lone requester therefore sees one IDLE bubble between its bursts.
- prio_mask changes only at burst ends.
- ready, last_vec and non-owner req bits are ignored for state updates, except during arbitration.

## Timing
- Reset values: state IDLE, grant_valid = 0, grant_one_hot = 0, grant_index = 0, prio_mask = all ones, beat_count = 0.
- Combinational outputs are 0 while in IDLE or during reset.
- RST has priority over all events, including mid-burst. On the edge after RST, state is as at reset, with no burst_end and no mask rotation.
- Arbitration latency: req asserted in cycle n while IDLE gives grant_valid in cycle n+1. A handoff decided in cycle n gives the new owner in cycle n+1.
- beat_fire, burst_end, burst_abort and preempt are valid in the same cycle as their inputs.
- The registered grant updates on the edge that ends the cycle.
- A burst has at most MAX_BEATS beats. beat_count never exceeds MAX_BEATS-1 while held.

## Test plan
All scenarios use WIDTH=4, MAX_BEATS=4.
- **Reset:** RST = 1 for 2 cycles with req_vec = 1111 → grant_valid = 0, grant_one_hot = 0000, grant_index = 0. After release with req = 1111, the next cycle gives grant_one_hot = 0001.
- **Single burst:** req = 0100, ready = 1, last on 3rd beat → grant 0100 from cycle 1, beat_fire in cycles 1–3, burst_end in cycle 3, grant_valid = 0 in cycle 4.
- **Round robin, back-to-back:** req = 1011, last_vec = 1111, ready = 1 → grants 0001, 0010, 1000, 0001 in consecutive cycles with no bubble, confirming wrap at index 3.
- **Ready stall:** owner 0010 with ready = 0 for 3 cycles → grant held, beat_fire = 0, beat_count unchanged. Then ready = 1 with last → burst_end.
- **Preemption:** req = 0011, last_vec = 0000, ready = 1, owner 0001 → preempt = 1 and burst_end = 1 on the 4th beat; next cycle grant = 0010.
- **Abort and reset mid-burst:**
  - Owner 0100 drops req → burst_abort = 1; with req = 1001 the next grant is 1000.
  - RST mid-burst with req = 1010 → the cycle after release gives grant 0010, showing prio_mask was restored to all ones.
